// File: rtl/axi_dma_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axi_dma_pkg
// Description : Shared types and constants for the AXI DMA burst reshaper:
//               AXI address-channel and data-mover descriptors, the default
//               transfer/request structs and the 4 KiB page constant.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_dma_pkg;

   // AXI bursts may never cross a 4 KiB boundary
   localparam int unsigned PAGE_SIZE = 4096;
   localparam int unsigned PAGE_BITS = 12;

   // AXI4 INCR bursts carry at most 256 beats
   localparam int unsigned MAX_BEATS = 256;

   // Default bus geometry used by the default request types
   localparam int unsigned AXI_DATA_WIDTH = 64;
   localparam int unsigned AXI_ADDR_WIDTH = 32;
   localparam int unsigned AXI_ID_WIDTH   = 4;

   // Byte-lane fields are sized generously so one descriptor fits any width
   localparam int unsigned DESC_OFFSET_WIDTH = 8;

   localparam logic [1:0] BURST_INCR = 2'b01;

   typedef enum logic {
      SIDE_IDLE = 1'b0,
      SIDE_BUSY = 1'b1
   } side_state_e;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_ADDR_WIDTH-1:0] addr;
      logic [7:0]                len;
      logic [2:0]                size;
      logic [1:0]                burst;
      logic [3:0]                cache;
      logic                      last;
   } desc_ax_t;

   typedef struct packed {
      logic [DESC_OFFSET_WIDTH-1:0] offset;
      logic [DESC_OFFSET_WIDTH-1:0] tailer;
      logic [DESC_OFFSET_WIDTH-1:0] shift;
   } desc_r_t;

   typedef struct packed {
      logic [DESC_OFFSET_WIDTH-1:0] offset;
      logic [DESC_OFFSET_WIDTH-1:0] tailer;
      logic [7:0]                   num_beats;
      logic                         is_single;
   } desc_w_t;

   typedef struct packed {
      desc_ax_t ar;
      desc_r_t  r;
   } dma_read_req_t;

   typedef struct packed {
      desc_ax_t aw;
      desc_w_t  w;
   } dma_write_req_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_ADDR_WIDTH-1:0] src;
      logic [AXI_ADDR_WIDTH-1:0] dst;
      logic [AXI_ADDR_WIDTH-1:0] num_bytes;
      logic [3:0]                cache_src;
      logic [3:0]                cache_dst;
   } dma_burst_req_t;

endpackage
`default_nettype wire

// File: rtl/axi_dma_burst_side.sv
`default_nettype none
// ============================================================================
// Module      : axi_dma_burst_side
// Description : One side (read or write) of the burst reshaper. Tracks the
//               current address and remaining byte count of a transfer and
//               derives the geometry of the next legal AXI burst from them.
// Config      : AXI_DMA_DEBURST_EN - cap every burst to a single beat.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_dma_burst_side
   import axi_dma_pkg::*;
#(
   parameter int unsigned DataWidth = AXI_DATA_WIDTH,
   parameter int unsigned AddrWidth = AXI_ADDR_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [AddrWidth-1:0]         start_addr,
   input  logic [AddrWidth-1:0]         start_bytes,
   input  logic                         handshake,
   output logic                         busy,
   output logic [AddrWidth-1:0]         addr,
   output logic [7:0]                   len,
   output logic [DESC_OFFSET_WIDTH-1:0] offset,
   output logic [DESC_OFFSET_WIDTH-1:0] tailer,
   output logic                         final_burst
);

   localparam int unsigned StrbWidth   = DataWidth / 8;
   localparam int unsigned OffsetWidth = $clog2(StrbWidth);

   side_state_e          state_q, state_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [AddrWidth-1:0] remaining_q, remaining_d;

   logic [OffsetWidth-1:0] offset_bits;
   logic [AddrWidth-1:0]   page_left;
   logic [AddrWidth-1:0]   beat_left;
   logic [AddrWidth-1:0]   bytes;
   logic [AddrWidth-1:0]   end_bytes;
   logic [AddrWidth-1:0]   beats;

   // Geometry of the burst starting at the current address
   always_comb begin
      offset_bits = addr_q[OffsetWidth-1:0];
      page_left   = AddrWidth'(PAGE_SIZE) - AddrWidth'(addr_q[PAGE_BITS-1:0]);
`ifdef AXI_DMA_DEBURST_EN
      beat_left   = AddrWidth'(StrbWidth) - AddrWidth'(offset_bits);
`else
      beat_left   = AddrWidth'(MAX_BEATS * StrbWidth) - AddrWidth'(offset_bits);
`endif
      bytes = remaining_q;
      if (page_left < bytes) begin
         bytes = page_left;
      end
      if (beat_left < bytes) begin
         bytes = beat_left;
      end
      end_bytes   = AddrWidth'(offset_bits) + bytes;
      beats       = (end_bytes + AddrWidth'(StrbWidth - 1)) >> OffsetWidth;
      len         = 8'(beats - AddrWidth'(1));
      offset      = DESC_OFFSET_WIDTH'(offset_bits);
      tailer      = DESC_OFFSET_WIDTH'(end_bytes[OffsetWidth-1:0]);
      final_burst = (remaining_q == bytes);
   end

   assign busy = (state_q == SIDE_BUSY);
   assign addr = addr_q;

   // Next state: load on start, step one burst per handshake
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      case (state_q)
         SIDE_IDLE: begin
            if (start && (start_bytes != '0)) begin
               state_d     = SIDE_BUSY;
               addr_d      = start_addr;
               remaining_d = start_bytes;
            end
         end
         SIDE_BUSY: begin
            if (handshake) begin
               addr_d      = addr_q + bytes;
               remaining_d = remaining_q - bytes;
               if (final_burst) begin
                  state_d = SIDE_IDLE;
               end
            end
         end
         default: state_d = SIDE_IDLE;
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SIDE_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/axi_dma_burst_reshaper.sv
`default_nettype none
// ============================================================================
// Module      : axi_dma_burst_reshaper
// Description : Splits a 1D DMA transfer into legal AXI INCR bursts, with
//               independent read and write sides running in parallel.
// Config      : AXI_DMA_DEBURST_EN - cap every burst to a single beat.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_dma_burst_reshaper
   import axi_dma_pkg::*;
#(
   parameter int unsigned DataWidth = AXI_DATA_WIDTH,
   parameter int unsigned AddrWidth = AXI_ADDR_WIDTH,
   parameter int unsigned IdWidth   = AXI_ID_WIDTH,
   parameter type burst_req_t = axi_dma_pkg::dma_burst_req_t,
   parameter type read_req_t  = axi_dma_pkg::dma_read_req_t,
   parameter type write_req_t = axi_dma_pkg::dma_write_req_t
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  burst_req_t burst_req_i,
   input  logic       valid_i,
   output logic       ready_o,
   output read_req_t  read_req_o,
   output logic       r_valid_o,
   input  logic       r_ready_i,
   output write_req_t write_req_o,
   output logic       w_valid_o,
   input  logic       w_ready_i
);

   localparam int unsigned StrbWidth   = DataWidth / 8;
   localparam int unsigned OffsetWidth = $clog2(StrbWidth);

   logic                         accept;
   logic [AddrWidth-1:0]         addr_diff;

   logic                         r_busy, w_busy;
   logic [AddrWidth-1:0]         r_addr, w_addr;
   logic [7:0]                   r_len, w_len;
   logic [DESC_OFFSET_WIDTH-1:0] r_offset, r_tailer, w_offset, w_tailer;
   logic                         r_final_unused, w_final;

   logic [IdWidth-1:0]           id_q;
   logic [3:0]                   cache_src_q, cache_dst_q;
   logic [DESC_OFFSET_WIDTH-1:0] shift_q;

   // A new transfer is taken only once both sides have drained
   assign ready_o   = !r_busy && !w_busy;
   assign accept    = valid_i && ready_o;
   assign addr_diff = burst_req_i.src - burst_req_i.dst;
   assign r_valid_o = r_busy;
   assign w_valid_o = w_busy;

   // Latch per-transfer attributes that stay constant over all bursts
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         id_q        <= '0;
         cache_src_q <= '0;
         cache_dst_q <= '0;
         shift_q     <= '0;
      end else if (accept) begin
         id_q        <= burst_req_i.id;
         cache_src_q <= burst_req_i.cache_src;
         cache_dst_q <= burst_req_i.cache_dst;
         shift_q     <= DESC_OFFSET_WIDTH'(addr_diff[OffsetWidth-1:0]);
      end
   end

   axi_dma_burst_side #(
      .DataWidth (DataWidth),
      .AddrWidth (AddrWidth)
   ) u_read_side (
      .clk         (clk_i),
      .rst_n       (rst_ni),
      .start       (accept),
      .start_addr  (burst_req_i.src),
      .start_bytes (burst_req_i.num_bytes),
      .handshake   (r_ready_i),
      .busy        (r_busy),
      .addr        (r_addr),
      .len         (r_len),
      .offset      (r_offset),
      .tailer      (r_tailer),
      .final_burst (r_final_unused)
   );

   axi_dma_burst_side #(
      .DataWidth (DataWidth),
      .AddrWidth (AddrWidth)
   ) u_write_side (
      .clk         (clk_i),
      .rst_n       (rst_ni),
      .start       (accept),
      .start_addr  (burst_req_i.dst),
      .start_bytes (burst_req_i.num_bytes),
      .handshake   (w_ready_i),
      .busy        (w_busy),
      .addr        (w_addr),
      .len         (w_len),
      .offset      (w_offset),
      .tailer      (w_tailer),
      .final_burst (w_final)
   );

   // Read request: driven only while the read side holds a burst
   always_comb begin
      read_req_o = '0;
      if (r_busy) begin
         read_req_o.ar.id    = id_q;
         read_req_o.ar.addr  = r_addr;
         read_req_o.ar.len   = r_len;
         read_req_o.ar.size  = 3'(OffsetWidth);
         read_req_o.ar.burst = BURST_INCR;
         read_req_o.ar.cache = cache_src_q;
         read_req_o.ar.last  = 1'b0;
         read_req_o.r.offset = r_offset;
         read_req_o.r.tailer = r_tailer;
         read_req_o.r.shift  = shift_q;
      end
   end

   // Write request: last flags the final write burst of the transfer
   always_comb begin
      write_req_o = '0;
      if (w_busy) begin
         write_req_o.aw.id       = id_q;
         write_req_o.aw.addr     = w_addr;
         write_req_o.aw.len      = w_len;
         write_req_o.aw.size     = 3'(OffsetWidth);
         write_req_o.aw.burst    = BURST_INCR;
         write_req_o.aw.cache    = cache_dst_q;
         write_req_o.aw.last     = w_final;
         write_req_o.w.offset    = w_offset;
         write_req_o.w.tailer    = w_tailer;
         write_req_o.w.num_beats = w_len;
         write_req_o.w.is_single = (w_len == 8'd0);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_dma_burst_reshaper.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_dma_burst_reshaper
// Description : Self-checking bench for axi_dma_burst_reshaper (64-bit data).
//               Directed vector table, hand sequences for back-pressure,
//               empty transfers and mid-transfer reset, then random traffic
//               checked against a queue-based reference model.
// Config      : AXI_DMA_DEBURST_EN - expectations follow the single-beat cap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_dma_burst_reshaper;
   import axi_dma_pkg::*;

   localparam int unsigned STRB = 8;
   localparam int          NVEC = 4;

   logic           clk = 1'b0;
   logic           rst_ni;
   dma_burst_req_t burst_req;
   logic           valid, ready;
   dma_read_req_t  read_req;
   logic           r_valid, r_ready;
   dma_write_req_t write_req;
   logic           w_valid, w_ready;

   always #5 clk = ~clk;

   axi_dma_burst_reshaper #(
      .DataWidth (64),
      .AddrWidth (32),
      .IdWidth   (4)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .burst_req_i (burst_req),
      .valid_i     (valid),
      .ready_o     (ready),
      .read_req_o  (read_req),
      .r_valid_o   (r_valid),
      .r_ready_i   (r_ready),
      .write_req_o (write_req),
      .w_valid_o   (w_valid),
      .w_ready_i   (w_ready)
   );

   int checks, errors;

   dma_read_req_t  exp_r[$];
   dma_write_req_t exp_w[$];

   int         rd_total, wr_total;
   logic [7:0] rd_len_log [256];
   logic [7:0] rd_tail_log[256];
   logic [7:0] rd_shift_log[256];
   logic [7:0] wr_len_log [256];
   logic       wr_last_log[256];

   logic           rand_ready, r_hold, w_hold;
   logic           prev_r_stall, prev_w_stall;
   dma_read_req_t  prev_r;
   dma_write_req_t prev_w;

   typedef struct {
      logic [31:0] src, dst, num;
      int          n_rd, n_wr;
      logic [7:0]  rd_len0, rd_tail0, wr_len_last, shift;
   } vec_t;
   vec_t vecs[NVEC];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: walk the transfer with plain arithmetic, one burst at a time
   task automatic model_push(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] num,
                             input logic [3:0] id, input logic [3:0] cs, input logic [3:0] cd);
      longint a, rem, off, b, cap, endb;
      logic [31:0] diff;
      logic [7:0] sh;
      dma_read_req_t  rr;
      dma_write_req_t wr;
      diff = src - dst;
      sh   = 8'(diff % STRB);
      for (int side = 0; side < 2; side++) begin
         a   = (side == 0) ? longint'(src) : longint'(dst);
         rem = longint'(num);
         while (rem > 0) begin
            off = a % STRB;
            b   = rem;
            cap = 4096 - (a % 4096);
            if (cap < b) b = cap;
`ifdef AXI_DMA_DEBURST_EN
            cap = STRB - off;
`else
            cap = 256 * STRB - off;
`endif
            if (cap < b) b = cap;
            endb = off + b;
            if (side == 0) begin
               rr = '0;
               rr.ar.id = id; rr.ar.addr = 32'(a); rr.ar.len = 8'((endb + STRB - 1) / STRB - 1);
               rr.ar.size = 3'd3; rr.ar.burst = 2'b01; rr.ar.cache = cs; rr.ar.last = 1'b0;
               rr.r.offset = 8'(off); rr.r.tailer = 8'(endb % STRB); rr.r.shift = sh;
               exp_r.push_back(rr);
            end else begin
               wr = '0;
               wr.aw.id = id; wr.aw.addr = 32'(a); wr.aw.len = 8'((endb + STRB - 1) / STRB - 1);
               wr.aw.size = 3'd3; wr.aw.burst = 2'b01; wr.aw.cache = cd; wr.aw.last = (rem == b);
               wr.w.offset = 8'(off); wr.w.tailer = 8'(endb % STRB);
               wr.w.num_beats = wr.aw.len; wr.w.is_single = (wr.aw.len == 8'd0);
               exp_w.push_back(wr);
            end
            a   += b;
            rem -= b;
         end
      end
   endtask

   // Observe outputs at the falling edge; handshakes complete on the next rise
   task automatic monitor();
      dma_read_req_t  er;
      dma_write_req_t ew;
      if (!rst_ni) begin
         prev_r_stall = 1'b0;
         prev_w_stall = 1'b0;
         return;
      end
      if (prev_r_stall) chk("rd_hold", 128'({r_valid, read_req}), 128'({1'b1, prev_r}));
      if (prev_w_stall) chk("wr_hold", 128'({w_valid, write_req}), 128'({1'b1, prev_w}));
      if (!r_valid) chk("rd_idle_zero", 128'(read_req), 128'(0));
      if (!w_valid) chk("wr_idle_zero", 128'(write_req), 128'(0));
      if (r_valid && r_ready) begin
         if (exp_r.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_extra: got burst addr %0h expected none", read_req.ar.addr);
         end else begin
            er = exp_r.pop_front();
            chk("rd_burst", 128'(read_req), 128'(er));
         end
         rd_len_log[rd_total % 256]   = read_req.ar.len;
         rd_tail_log[rd_total % 256]  = read_req.r.tailer;
         rd_shift_log[rd_total % 256] = read_req.r.shift;
         rd_total++;
      end
      if (w_valid && w_ready) begin
         if (exp_w.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr_extra: got burst addr %0h expected none", write_req.aw.addr);
         end else begin
            ew = exp_w.pop_front();
            chk("wr_burst", 128'(write_req), 128'(ew));
         end
         wr_len_log[wr_total % 256]  = write_req.aw.len;
         wr_last_log[wr_total % 256] = write_req.aw.last;
         wr_total++;
      end
      prev_r_stall = r_valid && !r_ready;
      prev_w_stall = w_valid && !w_ready;
      prev_r = read_req;
      prev_w = write_req;
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      r_ready = r_hold ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      w_ready = w_hold ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
   endtask

   task automatic send(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] num,
                       input logic [3:0] id, input logic [3:0] cs, input logic [3:0] cd);
      int n = 0;
      while (!ready && n < 3000) begin
         tick();
         n++;
      end
      if (!ready) begin
         checks++; errors++;
         $display("FAIL send_timeout: ready_o got 0 expected 1");
      end
      burst_req.id = id; burst_req.src = src; burst_req.dst = dst;
      burst_req.num_bytes = num; burst_req.cache_src = cs; burst_req.cache_dst = cd;
      valid = 1'b1;
      model_push(src, dst, num, id, cs, cd);
      tick();
      valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(ready && exp_r.size() == 0 && exp_w.size() == 0) && n < 3000) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL idle_timeout: pending rd %0d wr %0d expected 0", exp_r.size(), exp_w.size());
      end
   endtask

   initial begin
      int rd0, wr0;
      logic [31:0] src, num;
      checks = 0; errors = 0; rd_total = 0; wr_total = 0;
      rand_ready = 1'b0; r_hold = 1'b0; w_hold = 1'b0;
      prev_r_stall = 1'b0; prev_w_stall = 1'b0; prev_r = '0; prev_w = '0;
      rst_ni = 1'b0; valid = 1'b0; burst_req = '0; r_ready = 1'b1; w_ready = 1'b1;

      // src, dst, bytes, #rd, #wr, first rd len, first rd tailer, last wr len, shift
`ifdef AXI_DMA_DEBURST_EN
      vecs[0] = '{32'h4,    32'h0,    32'd20,  3, 3, 8'd0, 8'd0, 8'd0, 8'd4};
      vecs[1] = '{32'h3,    32'h5,    32'd8,   2, 2, 8'd0, 8'd0, 8'd0, 8'd6};
      vecs[2] = '{32'h0,    32'h0,    32'd16,  2, 2, 8'd0, 8'd0, 8'd0, 8'd0};
      vecs[3] = '{32'hFFC,  32'h2000, 32'd16,  3, 2, 8'd0, 8'd0, 8'd0, 8'd4};
`else
      vecs[0] = '{32'hFFC,  32'h2000, 32'd16,   2, 1, 8'd0,   8'd0, 8'd1,   8'd4};
      vecs[1] = '{32'h0,    32'h0,    32'd4096, 2, 2, 8'd255, 8'd0, 8'd255, 8'd0};
      vecs[2] = '{32'h3,    32'h5,    32'd8,    1, 1, 8'd1,   8'd3, 8'd1,   8'd6};
      vecs[3] = '{32'hFF8,  32'h1003, 32'd300,  2, 1, 8'd0,   8'd0, 8'd37,  8'd5};
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 128'(ready), 128'(1));
      chk("rst_r_valid", 128'(r_valid), 128'(0));
      chk("rst_w_valid", 128'(w_valid), 128'(0));
      chk("rst_read_req", 128'(read_req), 128'(0));
      chk("rst_write_req", 128'(write_req), 128'(0));
      rst_ni = 1'b1;
      tick();
      chk("post_rst_ready", 128'(ready), 128'(1));

      for (int v = 0; v < NVEC; v++) begin
         rd0 = rd_total;
         wr0 = wr_total;
         send(vecs[v].src, vecs[v].dst, vecs[v].num, 4'(v + 1), 4'h3, 4'hA);
         chk("first_valid_latency", 128'({r_valid, w_valid}), 128'(2'b11));
         wait_idle();
         chk("vec_n_rd", 128'(rd_total - rd0), 128'(vecs[v].n_rd));
         chk("vec_n_wr", 128'(wr_total - wr0), 128'(vecs[v].n_wr));
         chk("vec_rd_len0", 128'(rd_len_log[rd0 % 256]), 128'(vecs[v].rd_len0));
         chk("vec_rd_tail0", 128'(rd_tail_log[rd0 % 256]), 128'(vecs[v].rd_tail0));
         chk("vec_rd_shift", 128'(rd_shift_log[rd0 % 256]), 128'(vecs[v].shift));
         chk("vec_wr_len_last", 128'(wr_len_log[(wr_total - 1) % 256]), 128'(vecs[v].wr_len_last));
         chk("vec_wr_last_flag", 128'(wr_last_log[(wr_total - 1) % 256]), 128'(1));
         if (vecs[v].n_wr > 1)
            chk("vec_wr_first_not_last", 128'(wr_last_log[wr0 % 256]), 128'(0));
      end

      // Write side stalled: reads drain, write output held, no new transfer
      w_hold = 1'b1;
      w_ready = 1'b0;
      send(32'hFFC, 32'h2000, 32'd16, 4'h7, 4'h1, 4'h2);
      repeat (10) tick();
      chk("bp_reads_done", 128'(exp_r.size()), 128'(0));
      chk("bp_r_valid", 128'(r_valid), 128'(0));
      chk("bp_w_valid", 128'(w_valid), 128'(1));
      chk("bp_ready_low", 128'(ready), 128'(0));
      w_hold = 1'b0;
      wait_idle();
      chk("bp_ready_high", 128'(ready), 128'(1));

      // Empty transfer is swallowed
      send(32'h100, 32'h200, 32'd0, 4'h1, 4'h0, 4'h0);
      chk("zero_valids", 128'({r_valid, w_valid}), 128'(2'b00));
      chk("zero_ready", 128'(ready), 128'(1));
      tick();
      chk("zero_valids_later", 128'({r_valid, w_valid}), 128'(2'b00));

      // Reset in the middle of a transfer abandons it immediately
      r_hold = 1'b1; w_hold = 1'b1;
      r_ready = 1'b0; w_ready = 1'b0;
      send(32'h0, 32'h0, 32'd4096, 4'h2, 4'h0, 4'h0);
      tick();
      chk("pre_rst_valids", 128'({r_valid, w_valid}), 128'(2'b11));
      rst_ni = 1'b0;
      #1;
      chk("async_rst_valids", 128'({r_valid, w_valid}), 128'(2'b00));
      chk("async_rst_ready", 128'(ready), 128'(1));
      exp_r.delete();
      exp_w.delete();
      r_hold = 1'b0; w_hold = 1'b0;
      tick();
      rst_ni = 1'b1;
      tick();
      tick();
      chk("after_rst_valids", 128'({r_valid, w_valid}), 128'(2'b00));
      chk("after_rst_ready", 128'(ready), 128'(1));

      // Random transfers with random ready back-pressure
      rand_ready = 1'b1;
      for (int t = 0; t < 40; t++) begin
         src = $urandom_range(0, 32'h6FFF_FFFF);
         if ($urandom_range(0, 1) == 1) src[11:0] = 12'(12'hF00 + $urandom_range(0, 255));
         num = (t % 8 == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
         send(src, 32'($urandom_range(0, 32'h6FFF_FFFF)), num,
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      wait_idle();
      rand_ready = 1'b0;
      chk("drain_rd", 128'(exp_r.size()), 128'(0));
      chk("drain_wr", 128'(exp_w.size()), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
